// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one physical-memory port between the instruction fetch unit (master 0,
//   read-only) and the load/store unit (master 1). At most one transaction is in
//   flight: the winning request is latched in IDLE, issued to the slave with a
//   req/ready handshake, and the response is routed back to the owning master only.
//
//   Optional build macro: ARB_ROUND_ROBIN_EN
//     defined   - ties alternate via a 1-bit last_owner register (first tie -> IFU)
//     undefined - fixed priority, LSU wins ties
//
// Ports
//   clk, rst                         clock (rising edge), async active-high reset
//   m0_req/m0_addr                   IFU read request, held until m0_gnt
//   m0_gnt/m0_rvalid/m0_rdata        IFU accept pulse, response pulse, read data
//   m1_req/m1_we/m1_addr/m1_wdata/m1_wmask   LSU request, held until m1_gnt
//   m1_gnt/m1_rvalid/m1_rdata        LSU accept pulse, response pulse, read data (0 on writes)
//   s_req/s_we/s_addr/s_wdata/s_wmask  slave request and latched fields
//   s_ready/s_rvalid/s_rdata         slave accept, response valid, read data
//   busy                             transaction in progress (state != IDLE)
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned MASK_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [MASK_W-1:0] m1_wmask,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              s_req,
    output logic              s_we,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    output logic [MASK_W-1:0] s_wmask,
    input  logic              s_ready,
    input  logic              s_rvalid,
    input  logic [DATA_W-1:0] s_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;   // 0 = IFU, 1 = LSU
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0] mask_q, mask_d;
    logic              pick_m1;
    logic              done;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_owner_q, last_owner_d;

    // On a tie the master that was not served last wins; reset value 1 hands
    // the first tie to the IFU.
    assign pick_m1 = m1_req && (!m0_req || !last_owner_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_owner_q <= 1'b1;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end

    always_comb begin
        last_owner_d = last_owner_q;
        if (state_q == S_IDLE && (m0_req || m1_req)) begin
            last_owner_d = pick_m1;
        end
    end
`else
    assign pick_m1 = m1_req;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        m0_gnt  = 1'b0;
        m1_gnt  = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (m0_req || m1_req) begin
                    state_d = S_ISSUE;
                    if (pick_m1) begin
                        m1_gnt  = 1'b1;
                        owner_d = 1'b1;
                        we_d    = m1_we;
                        addr_d  = m1_addr;
                        wdata_d = m1_wdata;
                        mask_d  = m1_wmask;
                    end else begin
                        m0_gnt  = 1'b1;
                        owner_d = 1'b0;
                        we_d    = 1'b0;
                        addr_d  = m0_addr;
                        wdata_d = '0;
                        mask_d  = '1;
                    end
                end
            end
            S_ISSUE: begin
                if (s_ready) begin
                    // A zero-latency slave answers in the accept cycle.
                    if (s_rvalid) begin
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (s_rvalid) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign s_req     = (state_q == S_ISSUE);
    assign s_we      = we_q;
    assign s_addr    = addr_q;
    assign s_wdata   = wdata_q;
    assign s_wmask   = mask_q;
    assign busy      = (state_q != S_IDLE);
    assign m0_rvalid = done && !owner_q;
    assign m1_rvalid = done && owner_q;
    assign m0_rdata  = m0_rvalid ? s_rdata : '0;
    assign m1_rdata  = (m1_rvalid && !we_q) ? s_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_gnt, m0_rvalid;
    logic [31:0] m0_addr, m0_rdata;
    logic        m1_req, m1_we, m1_gnt, m1_rvalid;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wmask;
    logic        s_req, s_we, s_ready, s_rvalid, busy;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wmask;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MASK_W(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wmask(m1_wmask), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wmask(s_wmask), .s_ready(s_ready), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
        .busy(busy)
    );

    typedef struct {
        logic        m0_req;
        logic [31:0] m0_addr;
        logic        m1_req;
        logic        m1_we;
        logic [31:0] m1_addr;
        logic [31:0] m1_wdata;
        logic [3:0]  m1_wmask;
        logic        s_ready;
        logic        s_rvalid;
        logic [31:0] s_rdata;
        logic [1:0]  gnt;     // {m1_gnt, m0_gnt}
        logic [1:0]  rv;      // {m1_rvalid, m0_rvalid}
        logic [31:0] r0;
        logic [31:0] r1;
        logic        sreq;
        logic        busy;
        logic        chk_s;   // compare latched slave fields
        logic        swe;
        logic [31:0] saddr;
        logic [31:0] swdata;
        logic [3:0]  smask;
    } vec_t;

    vec_t tbl[64];
    vec_t cur;
    int   n = 0;

    task automatic stim(input logic q0, input logic [31:0] a0, input logic q1,
                        input logic we, input logic [31:0] a1, input logic [31:0] wd,
                        input logic [3:0] wm, input logic rdy, input logic rv,
                        input logic [31:0] rd);
        cur.m0_req = q0; cur.m0_addr = a0; cur.m1_req = q1; cur.m1_we = we;
        cur.m1_addr = a1; cur.m1_wdata = wd; cur.m1_wmask = wm;
        cur.s_ready = rdy; cur.s_rvalid = rv; cur.s_rdata = rd;
    endtask

    task automatic exp_o(input logic [1:0] g, input logic [1:0] v, input logic [31:0] r0,
                         input logic [31:0] r1, input logic sr, input logic bz,
                         input logic cs, input logic we, input logic [31:0] ad,
                         input logic [31:0] wd, input logic [3:0] mk);
        cur.gnt = g; cur.rv = v; cur.r0 = r0; cur.r1 = r1; cur.sreq = sr; cur.busy = bz;
        cur.chk_s = cs; cur.swe = we; cur.saddr = ad; cur.swdata = wd; cur.smask = mk;
        tbl[n] = cur;
        n++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, want);
        end
    endtask

    task automatic apply(input vec_t v);
        m0_req = v.m0_req; m0_addr = v.m0_addr; m1_req = v.m1_req; m1_we = v.m1_we;
        m1_addr = v.m1_addr; m1_wdata = v.m1_wdata; m1_wmask = v.m1_wmask;
        s_ready = v.s_ready; s_rvalid = v.s_rvalid; s_rdata = v.s_rdata;
    endtask

    task automatic check_vec(input vec_t v, input string tag);
        chk({tag, ".gnt"},      {30'd0, m1_gnt, m0_gnt},       {30'd0, v.gnt});
        chk({tag, ".rvalid"},   {30'd0, m1_rvalid, m0_rvalid}, {30'd0, v.rv});
        chk({tag, ".m0_rdata"}, m0_rdata, v.r0);
        chk({tag, ".m1_rdata"}, m1_rdata, v.r1);
        chk({tag, ".s_req"},    {31'd0, s_req}, {31'd0, v.sreq});
        chk({tag, ".busy"},     {31'd0, busy},  {31'd0, v.busy});
        if (v.chk_s) begin
            chk({tag, ".s_we"},    {31'd0, s_we}, {31'd0, v.swe});
            chk({tag, ".s_addr"},  s_addr, v.saddr);
            chk({tag, ".s_wdata"}, s_wdata, v.swdata);
            chk({tag, ".s_wmask"}, {28'd0, s_wmask}, {28'd0, v.smask});
        end
    endtask

    localparam logic [31:0] AI0 = 32'h8000_0000;
    localparam logic [31:0] AW  = 32'h8000_1000;
    localparam logic [31:0] AI1 = 32'h8000_0040;
    localparam logic [31:0] AL  = 32'h8000_2000;
    localparam logic [31:0] AI2 = 32'h8000_0100;
    localparam logic [31:0] AI3 = 32'h8000_0200;
    localparam logic [31:0] DW  = 32'hDEAD_BEEF;

    initial begin
        // ---- vector table ----
        // single IFU read, slave ready next cycle, response one cycle later
        stim(1, AI0, 0, 0, 0, 0, 0, 0, 0, 0);    exp_o(2'b01, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        stim(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);      exp_o(0, 0, 0, 0, 1, 1, 1, 0, AI0, 0, 4'hF);
        stim(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);      exp_o(0, 0, 0, 0, 0, 1, 1, 0, AI0, 0, 4'hF);
        stim(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0010_0093);
        exp_o(2'b01 & 2'b00, 2'b01, 32'h0010_0093, 0, 0, 1, 1, 0, AI0, 0, 4'hF);
        // LSU write against a zero-latency slave
        stim(0, 0, 1, 1, AW, DW, 4'h3, 0, 0, 0); exp_o(2'b10, 0, 0, 0, 0, 0, 1, 0, AI0, 0, 4'hF);
        stim(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h1234_5678);
        exp_o(0, 2'b10, 0, 0, 1, 1, 1, 1, AW, DW, 4'h3);
        // stray slave response while idle
        stim(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF);
        exp_o(0, 0, 0, 0, 0, 0, 1, 1, AW, DW, 4'h3);
`ifdef ARB_ROUND_ROBIN_EN
        // ties alternate IFU, LSU, IFU; pending LSU served afterwards
        stim(1, AI1, 1, 0, AL, 0, 4'hF, 0, 0, 0);  exp_o(2'b01, 0, 0, 0, 0, 0, 1, 1, AW, DW, 4'h3);
        stim(0, 0, 1, 0, AL, 0, 4'hF, 1, 1, 32'hCAFE_0001);
        exp_o(0, 2'b01, 32'hCAFE_0001, 0, 1, 1, 1, 0, AI1, 0, 4'hF);
        stim(1, AI1, 1, 0, AL, 0, 4'hF, 0, 0, 0);  exp_o(2'b10, 0, 0, 0, 0, 0, 1, 0, AI1, 0, 4'hF);
        stim(1, AI1, 0, 0, 0, 0, 0, 1, 1, 32'hCAFE_0002);
        exp_o(0, 2'b10, 0, 32'hCAFE_0002, 1, 1, 1, 0, AL, 0, 4'hF);
        stim(1, AI1, 1, 0, AL, 0, 4'hF, 0, 0, 0);  exp_o(2'b01, 0, 0, 0, 0, 0, 1, 0, AL, 0, 4'hF);
        stim(0, 0, 1, 0, AL, 0, 4'hF, 1, 1, 32'hCAFE_0003);
        exp_o(0, 2'b01, 32'hCAFE_0003, 0, 1, 1, 1, 0, AI1, 0, 4'hF);
        stim(0, 0, 1, 0, AL, 0, 4'hF, 0, 0, 0);    exp_o(2'b10, 0, 0, 0, 0, 0, 1, 0, AI1, 0, 4'hF);
        stim(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hCAFE_0004);
        exp_o(0, 2'b10, 0, 32'hCAFE_0004, 1, 1, 1, 0, AL, 0, 4'hF);
`else
        // LSU wins both ties; IFU waits with req held
        stim(1, AI1, 1, 0, AL, 0, 4'hF, 0, 0, 0);  exp_o(2'b10, 0, 0, 0, 0, 0, 1, 1, AW, DW, 4'h3);
        stim(1, AI1, 1, 0, AL, 0, 4'hF, 1, 1, 32'hCAFE_0001);
        exp_o(0, 2'b10, 0, 32'hCAFE_0001, 1, 1, 1, 0, AL, 0, 4'hF);
        stim(1, AI1, 1, 0, AL, 0, 4'hF, 0, 0, 0);  exp_o(2'b10, 0, 0, 0, 0, 0, 1, 0, AL, 0, 4'hF);
        stim(1, AI1, 0, 0, 0, 0, 0, 1, 1, 32'hCAFE_0002);
        exp_o(0, 2'b10, 0, 32'hCAFE_0002, 1, 1, 1, 0, AL, 0, 4'hF);
        stim(1, AI1, 0, 0, 0, 0, 0, 0, 0, 0);      exp_o(2'b01, 0, 0, 0, 0, 0, 1, 0, AL, 0, 4'hF);
        stim(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hCAFE_0003);
        exp_o(0, 2'b01, 32'hCAFE_0003, 0, 1, 1, 1, 0, AI1, 0, 4'hF);
`endif
        // slave stalls 5 cycles; IFU keeps req high and must not be re-granted
        stim(1, AI2, 0, 0, 0, 0, 0, 0, 0, 0);      exp_o(2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int unsigned k = 0; k < 5; k++) begin
            stim(1, AI2, 0, 0, 0, 0, 0, 0, 0, 0);  exp_o(0, 0, 0, 0, 1, 1, 1, 0, AI2, 0, 4'hF);
        end
        stim(1, AI2, 0, 0, 0, 0, 0, 1, 0, 0);      exp_o(0, 0, 0, 0, 1, 1, 1, 0, AI2, 0, 4'hF);
        stim(1, AI2, 0, 0, 0, 0, 0, 0, 1, 32'h0BAD_F00D);
        exp_o(0, 2'b01, 32'h0BAD_F00D, 0, 0, 1, 1, 0, AI2, 0, 4'hF);
        // new request, brought into WAIT for the reset-abort sequence
        stim(1, AI3, 0, 0, 0, 0, 0, 0, 0, 0);      exp_o(2'b01, 0, 0, 0, 0, 0, 1, 0, AI2, 0, 4'hF);
        stim(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);        exp_o(0, 0, 0, 0, 1, 1, 1, 0, AI3, 0, 4'hF);

        // ---- reset state ----
        stim(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply(cur);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        exp_o(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        n--;
        check_vec(cur, "reset");
        rst = 1'b0;

        // ---- table ----
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            apply(tbl[i]);
            #1;
            check_vec(tbl[i], $sformatf("v%0d", i));
        end

        // ---- asynchronous reset while waiting for the slave ----
        @(negedge clk);
        stim(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply(cur);
        #1;
        exp_o(0, 0, 0, 0, 0, 1, 1, 0, AI3, 0, 4'hF);
        n--;
        check_vec(cur, "wait_pre_rst");
        #1 rst = 1'b1;
        #1;
        exp_o(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        n--;
        check_vec(cur, "rst_async");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        stim(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA5A5_A5A5);
        apply(cur);
        #1;
        check_vec(cur, "late_rvalid");
        @(negedge clk);
        stim(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply(cur);
        #1;
        check_vec(cur, "idle_after_late");

        // ---- first tie after reset ----
        @(negedge clk);
        stim(1, AI1, 1, 0, AL, 0, 4'hF, 0, 0, 0);
        apply(cur);
        #1;
`ifdef ARB_ROUND_ROBIN_EN
        exp_o(2'b01, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
`else
        exp_o(2'b10, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
`endif
        n--;
        check_vec(cur, "tie_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
